// File: rtl/oursring_pkg.sv
// -----------------------------------------------------------------------------
// oursring_pkg
//   Shared definitions for the oursring request/response path.
//   - port_idx_w(n)   : width of a master-port index, max(1, clog2(n))
//   - port_idx_t      : port index type for the default 3-port ring
//   - onehot_to_idx() : grant vector to port index (lowest set bit wins)
//   No ports (package).
// -----------------------------------------------------------------------------
package oursring_pkg;

  // Widest grant vector the encoder accepts.
  localparam int MAX_PORTS = 32;

  // A single-port ring still needs a 1-bit index so that vectors stay legal.
  function automatic int port_idx_w(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

  localparam int N_IN_PORT_DEF = 3;
  localparam int PW_DEF        = port_idx_w(N_IN_PORT_DEF);

  typedef logic [PW_DEF-1:0] port_idx_t;

  // Scanning from the top down leaves the lowest set index as the result,
  // which defines the behaviour for an (unsupported) multi-hot grant.
  function automatic logic [31:0] onehot_to_idx(input logic [MAX_PORTS-1:0] vec);
    logic [31:0] idx;
    idx = 32'd0;
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 32'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/oursring_ord_fifo.sv
// -----------------------------------------------------------------------------
// oursring_ord_fifo
//   Small synchronous order FIFO with wrap-bit pointers.
//   Ports:
//     clk, rstn      : clock, asynchronous active-low reset
//     push, din      : write request and data (dropped when full)
//     pop            : remove head entry (ignored when empty)
//     head           : current head entry (valid when !empty)
//     full, empty    : status, combinational from the registered pointers
//     wr_en          : a write actually took place this cycle
// -----------------------------------------------------------------------------
module oursring_ord_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             wr_en
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             rd_en_s;

  // Equal index with opposite wrap bits means every slot is occupied.
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign wr_en   = push & ~full;
  assign rd_en_s = pop & ~empty;
  assign head    = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer registers; each wraps naturally through its extra bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Entry storage, cleared on reset so head never shows stale data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_r[wr_ptr_r[AW-1:0]] <= din;
      end
    end
  end

endmodule

// File: rtl/oursring_resp_router_chk.sv
// -----------------------------------------------------------------------------
// oursring_resp_router_chk
//   Simulation-only checker for oursring_resp_router.
//   Ports (all inputs):
//     clk, rstn           : clock, asynchronous active-low reset
//     aw_grant, ar_grant  : observed valid & grant vectors
//     aw_wr_en, ar_wr_en  : an order entry was written this cycle
//     aw_full, ar_full    : queue full flags
// -----------------------------------------------------------------------------
module oursring_resp_router_chk #(
  parameter int N_IN_PORT = 3
) (
  input logic                 clk,
  input logic                 rstn,
  input logic [N_IN_PORT-1:0] aw_grant,
  input logic [N_IN_PORT-1:0] ar_grant,
  input logic                 aw_wr_en,
  input logic                 aw_full,
  input logic                 ar_wr_en,
  input logic                 ar_full
);

  // Grants are one-hot or zero, and a full queue never takes a write.
  always @(posedge clk) begin
    if (rstn) begin
      assert ($onehot0(aw_grant)) else $error("oursring_resp_router: AW grant not one-hot");
      assert ($onehot0(ar_grant)) else $error("oursring_resp_router: AR grant not one-hot");
      assert (!(aw_wr_en && aw_full)) else $error("oursring_resp_router: W queue written while full");
      assert (!(ar_wr_en && ar_full)) else $error("oursring_resp_router: R queue written while full");
    end
  end

endmodule

// File: rtl/oursring_resp_router.sv
// -----------------------------------------------------------------------------
// oursring_resp_router
//   Records the winning master of every AW/AR grant in order and steers the
//   single ring-side B and R streams back to that master (handshakes only).
//   Build option: OURSRING_RESP_ROUTER_ERR_EN enables the sticky error flags
//   err_ovf / err_unexp; without it both outputs are tied low.
//   Ports:
//     clk, rstn                 : clock, asynchronous active-low reset
//     i_awvalid/i_awready       : observed AW valid and arbiter grant
//     i_arvalid/i_arready       : observed AR valid and arbiter grant
//     aw_full/ar_full           : order queue full (gates arbiter ready)
//     o_bvalid/o_bready         : ring-side B handshake
//     o_rvalid/o_rlast/o_rready : ring-side R handshake
//     i_bvalid/i_bready         : per-master B handshake
//     i_rvalid/i_rready         : per-master R handshake
//     b_sel/r_sel               : index of the current B/R destination
//     err_ovf                   : sticky, grant while the queue was full
//     err_unexp                 : sticky, response while the queue was empty
// -----------------------------------------------------------------------------
module oursring_resp_router
  import oursring_pkg::*;
#(
  parameter int N_IN_PORT  = 3,
  parameter int OSTD_DEPTH = 4,
  localparam int PW        = port_idx_w(N_IN_PORT)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_IN_PORT-1:0] i_awvalid,
  input  logic [N_IN_PORT-1:0] i_awready,
  input  logic [N_IN_PORT-1:0] i_arvalid,
  input  logic [N_IN_PORT-1:0] i_arready,
  output logic                 aw_full,
  output logic                 ar_full,
  input  logic                 o_bvalid,
  output logic                 o_bready,
  input  logic                 o_rvalid,
  input  logic                 o_rlast,
  output logic                 o_rready,
  output logic [N_IN_PORT-1:0] i_bvalid,
  input  logic [N_IN_PORT-1:0] i_bready,
  output logic [N_IN_PORT-1:0] i_rvalid,
  input  logic [N_IN_PORT-1:0] i_rready,
  output logic [PW-1:0]        b_sel,
  output logic [PW-1:0]        r_sel,
  output logic                 err_ovf,
  output logic                 err_unexp
);

  logic [N_IN_PORT-1:0] aw_grant_s;
  logic [N_IN_PORT-1:0] ar_grant_s;
  logic                 aw_push_s;
  logic                 ar_push_s;
  logic [PW-1:0]        aw_idx_s;
  logic [PW-1:0]        ar_idx_s;
  logic [PW-1:0]        w_head_s;
  logic [PW-1:0]        r_head_s;
  logic                 w_empty_s;
  logic                 r_empty_s;
  logic                 w_wr_en_s;
  logic                 r_wr_en_s;
  logic                 b_pop_s;
  logic                 r_pop_s;

  assign aw_grant_s = i_awvalid & i_awready;
  assign ar_grant_s = i_arvalid & i_arready;
  assign aw_push_s  = |aw_grant_s;
  assign ar_push_s  = |ar_grant_s;
  assign aw_idx_s   = PW'(onehot_to_idx(MAX_PORTS'(aw_grant_s)));
  assign ar_idx_s   = PW'(onehot_to_idx(MAX_PORTS'(ar_grant_s)));

  // The ready outputs are already forced low on an empty queue, so an
  // unexpected response can never pop.
  assign b_pop_s = o_bvalid & o_bready;
  // A read burst stays locked to its port until the last beat handshakes.
  assign r_pop_s = o_rvalid & o_rready & o_rlast;

  oursring_ord_fifo #(
    .WIDTH (PW),
    .DEPTH (OSTD_DEPTH)
  ) u_w_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (aw_push_s),
    .din   (aw_idx_s),
    .pop   (b_pop_s),
    .head  (w_head_s),
    .full  (aw_full),
    .empty (w_empty_s),
    .wr_en (w_wr_en_s)
  );

  oursring_ord_fifo #(
    .WIDTH (PW),
    .DEPTH (OSTD_DEPTH)
  ) u_r_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (ar_push_s),
    .din   (ar_idx_s),
    .pop   (r_pop_s),
    .head  (r_head_s),
    .full  (ar_full),
    .empty (r_empty_s),
    .wr_en (r_wr_en_s)
  );

  // B steering: only the head port sees valid and supplies ready.
  always_comb begin
    i_bvalid = '0;
    o_bready = 1'b0;
    b_sel    = '0;
    if (!w_empty_s) begin
      b_sel = w_head_s;
      for (int p = 0; p < N_IN_PORT; p++) begin
        if (w_head_s == PW'(p)) begin
          i_bvalid[p] = o_bvalid;
          o_bready    = i_bready[p];
        end else begin
          i_bvalid[p] = 1'b0;
        end
      end
    end else begin
      i_bvalid = '0;
      o_bready = 1'b0;
    end
  end

  // R steering: same scheme as B.
  always_comb begin
    i_rvalid = '0;
    o_rready = 1'b0;
    r_sel    = '0;
    if (!r_empty_s) begin
      r_sel = r_head_s;
      for (int p = 0; p < N_IN_PORT; p++) begin
        if (r_head_s == PW'(p)) begin
          i_rvalid[p] = o_rvalid;
          o_rready    = i_rready[p];
        end else begin
          i_rvalid[p] = 1'b0;
        end
      end
    end else begin
      i_rvalid = '0;
      o_rready = 1'b0;
    end
  end

`ifdef OURSRING_RESP_ROUTER_ERR_EN
  logic err_ovf_r;
  logic err_unexp_r;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_ovf_r   <= 1'b0;
      err_unexp_r <= 1'b0;
    end else begin
      err_ovf_r   <= err_ovf_r | (aw_push_s & aw_full) | (ar_push_s & ar_full);
      err_unexp_r <= err_unexp_r | (o_bvalid & w_empty_s) | (o_rvalid & r_empty_s);
    end
  end

  assign err_ovf   = err_ovf_r;
  assign err_unexp = err_unexp_r;
`else
  assign err_ovf   = 1'b0;
  assign err_unexp = 1'b0;
`endif

`ifndef SYNTHESIS
  oursring_resp_router_chk #(
    .N_IN_PORT (N_IN_PORT)
  ) u_chk (
    .clk      (clk),
    .rstn     (rstn),
    .aw_grant (aw_grant_s),
    .ar_grant (ar_grant_s),
    .aw_wr_en (w_wr_en_s),
    .aw_full  (aw_full),
    .ar_wr_en (r_wr_en_s),
    .ar_full  (ar_full)
  );
`endif

endmodule

// File: tb/tb_oursring_resp_router.sv
// -----------------------------------------------------------------------------
// tb_oursring_resp_router
//   Directed scenarios followed by random traffic; every cycle the outputs are
//   compared against an order-queue model built from plain SV queues.
// -----------------------------------------------------------------------------
module tb_oursring_resp_router;

  localparam int N = 3;
  localparam int D = 4;
`ifdef OURSRING_RESP_ROUTER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] i_awvalid, i_awready, i_arvalid, i_arready;
  logic         aw_full, ar_full;
  logic         o_bvalid, o_bready, o_rvalid, o_rlast, o_rready;
  logic [N-1:0] i_bvalid, i_bready, i_rvalid, i_rready;
  logic [1:0]   b_sel, r_sel;
  logic         err_ovf, err_unexp;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: ordered lists of destination ports plus sticky flags.
  int wq[$];
  int rq[$];
  bit m_ovf;
  bit m_unexp;

  always #5 clk = ~clk;

  oursring_resp_router #(.N_IN_PORT(N), .OSTD_DEPTH(D)) dut (
    .clk(clk), .rstn(rstn),
    .i_awvalid(i_awvalid), .i_awready(i_awready),
    .i_arvalid(i_arvalid), .i_arready(i_arready),
    .aw_full(aw_full), .ar_full(ar_full),
    .o_bvalid(o_bvalid), .o_bready(o_bready),
    .o_rvalid(o_rvalid), .o_rlast(o_rlast), .o_rready(o_rready),
    .i_bvalid(i_bvalid), .i_bready(i_bready),
    .i_rvalid(i_rvalid), .i_rready(i_rready),
    .b_sel(b_sel), .r_sel(r_sel),
    .err_ovf(err_ovf), .err_unexp(err_unexp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    int r;
    r = 0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Settle, then compare every output against the model.
  task automatic check_now();
    logic [N-1:0] ebv, erv;
    logic         ebr, err_rdy;
    int           bs, rs;
    #1;
    ebv = '0; ebr = 1'b0; bs = 0;
    if (wq.size() > 0) begin
      bs  = wq[0];
      ebr = i_bready[bs];
      if (o_bvalid) ebv[bs] = 1'b1;
    end
    erv = '0; err_rdy = 1'b0; rs = 0;
    if (rq.size() > 0) begin
      rs      = rq[0];
      err_rdy = i_rready[rs];
      if (o_rvalid) erv[rs] = 1'b1;
    end
    chk("i_bvalid",  32'(i_bvalid),  32'(ebv));
    chk("o_bready",  32'(o_bready),  32'(ebr));
    chk("b_sel",     32'(b_sel),     32'(bs));
    chk("i_rvalid",  32'(i_rvalid),  32'(erv));
    chk("o_rready",  32'(o_rready),  32'(err_rdy));
    chk("r_sel",     32'(r_sel),     32'(rs));
    chk("aw_full",   32'(aw_full),   32'(wq.size() == D));
    chk("ar_full",   32'(ar_full),   32'(rq.size() == D));
    chk("err_ovf",   32'(err_ovf),   32'(ERR_EN && m_ovf));
    chk("err_unexp", 32'(err_unexp), 32'(ERR_EN && m_unexp));
  endtask

  // Clock edge: advance the model with the inputs that were present at the edge.
  task automatic tick();
    logic [N-1:0] g;
    bit wfull, rfull, bpop, rpop;
    @(posedge clk);
    if (!rstn) begin
      wq.delete(); rq.delete(); m_ovf = 1'b0; m_unexp = 1'b0;
    end else begin
      wfull = (wq.size() == D);
      rfull = (rq.size() == D);
      bpop  = (wq.size() > 0) && o_bvalid && i_bready[wq[0]];
      rpop  = (rq.size() > 0) && o_rvalid && i_rready[rq[0]] && o_rlast;
      if ((o_bvalid && wq.size() == 0) || (o_rvalid && rq.size() == 0)) m_unexp = 1'b1;
      if (bpop) void'(wq.pop_front());
      if (rpop) void'(rq.pop_front());
      g = i_awvalid & i_awready;
      if (g != '0) begin
        if (wfull) m_ovf = 1'b1;
        else wq.push_back(lowest(g));
      end
      g = i_arvalid & i_arready;
      if (g != '0) begin
        if (rfull) m_ovf = 1'b1;
        else rq.push_back(lowest(g));
      end
    end
    #1;
  endtask

  task automatic cycle();
    check_now();
    tick();
  endtask

  task automatic idle_inputs();
    i_awvalid = '0; i_awready = '0; i_arvalid = '0; i_arready = '0;
    o_bvalid = 1'b0; o_rvalid = 1'b0; o_rlast = 1'b0;
    i_bready = '0; i_rready = '0;
  endtask

  task automatic ar_grant(input int p);
    i_arvalid = '0; i_arready = '0;
    i_arvalid[p] = 1'b1; i_arready[p] = 1'b1;
  endtask

  initial begin
    int k;
    logic [4:0] rr_pat;
    rr_pat = 5'b11101; // i_rready[1] per beat cycle, LSB first: 1,0,1,1,1
    idle_inputs();
    m_ovf = 1'b0; m_unexp = 1'b0;
    rstn = 1'b0;
    #12;
    check_now();
    rstn = 1'b1;

    // Sequential AW grants: port 2, then port 0; two B responses.
    i_awvalid = 3'b100; i_awready = 3'b100; cycle();
    i_awvalid = 3'b001; i_awready = 3'b001; cycle();
    i_awvalid = '0; i_awready = '0;
    i_bready = 3'b111; o_bvalid = 1'b1;
    check_now(); chk("tp_b_first", 32'(i_bvalid), 32'(3'b100)); tick();
    check_now(); chk("tp_b_second", 32'(i_bvalid), 32'(3'b001)); tick();
    o_bvalid = 1'b0;
    check_now(); chk("tp_b_empty", 32'(o_bready), 32'(1'b0)); tick();

    // 4-beat R burst to port 1 with toggling ready.
    ar_grant(1); cycle();
    i_arvalid = '0; i_arready = '0;
    k = 0;
    o_rvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      i_rready = 3'b101;
      i_rready[1] = rr_pat[c];
      o_rlast = (c == 4);
      check_now();
      chk("tp_r_sel", 32'(r_sel), 32'd1);
      chk("tp_r_valid", 32'(i_rvalid), 32'(3'b010));
      tick();
    end
    o_rvalid = 1'b0; o_rlast = 1'b0; i_rready = '0;
    check_now(); chk("tp_r_popped", 32'(rq.size()), 32'd0); tick();

    // Fill the R queue, then force a fifth grant.
    ar_grant(0); cycle();
    ar_grant(1); cycle();
    ar_grant(2); cycle();
    ar_grant(0); cycle();
    check_now(); chk("tp_ar_full", 32'(ar_full), 32'd1);
    ar_grant(2); tick();
    i_arvalid = '0; i_arready = '0;
    check_now(); chk("tp_err_ovf", 32'(err_ovf), 32'(ERR_EN)); tick();

    // Drain two single-beat reads, then pop and push in the same cycle.
    o_rvalid = 1'b1; o_rlast = 1'b1; i_rready = 3'b111;
    cycle(); cycle();
    ar_grant(0);
    check_now(); chk("tp_same_head", 32'(r_sel), 32'd2); tick();
    i_arvalid = '0; i_arready = '0; o_rvalid = 1'b0;
    check_now(); chk("tp_same_cnt", 32'(rq.size()), 32'd2); tick();
    o_rvalid = 1'b1;
    cycle(); cycle();
    o_rvalid = 1'b0; o_rlast = 1'b0; i_rready = '0;

    // Unexpected B on an empty W queue.
    o_bvalid = 1'b1; i_bready = 3'b111;
    check_now(); chk("tp_unexp_rdy", 32'(o_bready), 32'd0); tick();
    o_bvalid = 1'b0;
    check_now(); chk("tp_err_unexp", 32'(err_unexp), 32'(ERR_EN)); tick();

    // Asynchronous reset during beat 2 of a 4-beat burst to port 2.
    ar_grant(2); cycle();
    i_arvalid = '0; i_arready = '0;
    o_rvalid = 1'b1; o_rlast = 1'b0; i_rready = 3'b111;
    cycle();
    rstn = 1'b0;
    wq.delete(); rq.delete(); m_ovf = 1'b0; m_unexp = 1'b0;
    check_now(); chk("tp_rst_rvalid", 32'(i_rvalid), 32'd0);
    tick();
    rstn = 1'b1;
    cycle();
    o_rlast = 1'b1;
    cycle();
    o_rvalid = 1'b0; o_rlast = 1'b0;
    check_now(); chk("tp_rst_unexp", 32'(err_unexp), 32'(ERR_EN)); tick();

    // Random traffic with one-hot-or-zero grants.
    for (int c = 0; c < 400; c++) begin
      i_awvalid = 3'($urandom_range(0, 7));
      i_awready = '0;
      k = $urandom_range(0, 4);
      if (k < N) i_awready[k] = 1'b1;
      i_arvalid = 3'($urandom_range(0, 7));
      i_arready = '0;
      k = $urandom_range(0, 4);
      if (k < N) i_arready[k] = 1'b1;
      o_bvalid = 1'($urandom_range(0, 1));
      o_rvalid = 1'($urandom_range(0, 1));
      o_rlast  = ($urandom_range(0, 2) == 0);
      i_bready = 3'($urandom_range(0, 7));
      i_rready = 3'($urandom_range(0, 7));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/oursring_resp_router.md
Name: oursring_resp_router

Overview:
- Companion stage directly downstream of the oursring request arbiter.
- Records which master port won each AW and AR grant, in grant order.
- Steers the returning single-stream B and R responses back to the originating master port by valid/ready routing.
- Payload buses are broadcast outside this block; it only owns handshakes, ordering and overflow/underflow checking.

Parameters:
- N_IN_PORT, 3, number of master ports; must equal the arbiter's N_IN_PORT.
- OSTD_DEPTH, 4, max outstanding writes and, separately, max outstanding reads; power of 2, >= 2.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- i_awvalid  in  N_IN_PORT  master AW valid (observed).
- i_awready  in  N_IN_PORT  arbiter AW grant (observed); at most one bit set.
- i_arvalid  in  N_IN_PORT  master AR valid (observed).
- i_arready  in  N_IN_PORT  arbiter AR grant (observed); at most one bit set.
- aw_full  out  1  write order queue full; wrapper ANDs ~aw_full into arbiter o_awready.
- ar_full  out  1  read order queue full; wrapper ANDs ~ar_full into arbiter o_arready.
- o_bvalid  in  1  ring-side B valid.
- o_bready  out  1  ring-side B ready.
- o_rvalid  in  1  ring-side R valid.
- o_rlast  in  1  ring-side R last beat.
- o_rready  out  1  ring-side R ready.
- i_bvalid  out  N_IN_PORT  per-master B valid.
- i_bready  in  N_IN_PORT  per-master B ready.
- i_rvalid  out  N_IN_PORT  per-master R valid.
- i_rready  in  N_IN_PORT  per-master R ready.
- b_sel  out  PW  index of current B destination; PW = max(1, $clog2(N_IN_PORT)).
- r_sel  out  PW  index of current R destination.
- err_ovf  out  1  sticky: grant seen while the matching queue was full.
- err_unexp  out  1  sticky: o_bvalid or o_rvalid seen while the matching queue was empty.

Behaviour:
- Queues:
  - Two independent order queues, W (B) and R, each OSTD_DEPTH entries of PW bits.
  - Implementation: registered read/write pointers with an extra wrap bit.
- Push:
  - W queue pushes encode(i_awvalid & i_awready) when that vector is nonzero.
  - R queue pushes encode(i_arvalid & i_arready) when that vector is nonzero.
- Full flags: aw_full/ar_full = count == OSTD_DEPTH, combinational from registered pointers.
- B routing:
  - Queue non-empty, head h: i_bvalid[h] = o_bvalid, other i_bvalid bits 0, o_bready = i_bready[h], b_sel = h.
  - Queue empty: all i_bvalid = 0, o_bready = 0, b_sel = 0.
  - Pop on o_bvalid & o_bready.
- R routing:
  - Same scheme as B, using i_rvalid/i_rready/r_sel.
  - Pop only on o_rvalid & o_rready & o_rlast; bursts of any length stay locked to one port.
- Latency:
  - A pushed entry becomes head visible at the earliest the next cycle.
  - No same-cycle push-to-route bypass.
  - Routing itself is combinational, zero cycles.
- Simultaneous push and pop on a non-empty queue: both occur, count unchanged.
- Push while full: entry dropped, pointers unchanged, err_ovf set next cycle.
- Response while empty: not acknowledged (ready stays 0), err_unexp set next cycle.
- Non-one-hot grant vector: lowest set index is pushed (defined, not supported).
- Wrap-around: pointers wrap modulo OSTD_DEPTH; the wrap bit distinguishes full from empty.
- Reset (asynchronous, also mid-burst):
  - Pointers cleared, both queues empty, errors cleared.
  - Outputs: aw_full=0, ar_full=0, all valid/ready 0, sel=0.
  - A mid-burst R sequence is abandoned; later beats raise err_unexp.
- Non-synthesis assertions: grant vectors one-hot-or-zero; no push while full.

Optional Feature:
- Macro: OURSRING_RESP_ROUTER_ERR_EN.
- Defined: err_ovf/err_unexp sticky registers implemented as described.
- Undefined: both outputs tied 0, no flops; all other behaviour unchanged.

Decomposition:
- Shared oursring package holds:
  - the port-index width constant/function (max(1, clog2(N))),
  - the port-index typedef,
  - the one-hot-to-index encode function, also reusable by the arbiter.
- One natural sub-module, oursring_ord_fifo:
  - parameterised width/depth sync FIFO with push, pop, head, full, empty, and an asynchronous active-low reset;
  - instantiated twice.

Test Plan:
- Sequential grants: AW grants port 2, then port 0 (cycles 1, 2); two B responses with i_bready=all 1 -> first goes to i_bvalid=3'b100, second to 3'b001, then o_bready=0 and queue empty.
- R burst: AR grant port 1; 4-beat R with o_rlast on beat 4 and i_rready[1] toggling 1,0,1,1,1 -> all beats to port 1 only; pop only after beat 4 handshake; r_sel=1 throughout.
- Full queue: OSTD_DEPTH=4, four AR grants with no R -> ar_full=1 after 4th; 5th forced grant -> entry dropped, err_ovf=1 (macro on) / 0 (macro off).
- Same cycle: queue holds 2 entries, R last-beat pop and new AR grant (port 0) in the same cycle -> count stays 2; new entry becomes head after remaining entry.
- Unexpected response: o_bvalid=1 with empty W queue -> o_bready=0, all i_bvalid=0, err_unexp=1 next cycle.
- Async reset mid-burst: rstn low during beat 2 of a 4-beat R -> immediate clear, ar_full=0, err flags 0; after release, residual beats give err_unexp=1.
